var_delay_line: RTL and testbench
=================================

# var_delay_line

Runtime-programmable delay line that returns stored samples. A write side stores one sample per enabled cycle into a circular buffer of `MAX_LEN` entries. A read side returns the sample written `dly` enable-cycles earlier. With fixed `dly = L`, `out` is cycle-identical to the team's fixed-length `LEN = L` delay chain, after the fill period and with `out` zeroed until then. Used in datapaths whose alignment latency is set by software or a mode register instead of at elaboration.

## Interface
Parameters:
- `DW`, 8, sample width in bits.
- `MAX_LEN`, 16, buffer depth and largest supported delay; power of two, ≥ 2.
- `AW`, `$clog2(MAX_LEN+1)`, width of `dly` (derived, not overridden).

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high; clears pointer and fill count.
- `en`  input  1  sample enable; one write and one read-advance per enabled edge.
- `dly`  input  AW  requested delay in enable-cycles, 0..MAX_LEN; values above MAX_LEN clamp to MAX_LEN.
- `in`  input  DW  sample captured on an enabled edge.
- `out`  output  DW  delayed sample; zero while `out_vld` is low.
- `out_vld`  output  1  high when `out` holds a sample actually written since reset.

## Operation
- State:
  - buffer `mem[0:MAX_LEN-1]`, not reset;
  - write pointer `wptr`, log2(MAX_LEN) bits, wraps modulo MAX_LEN;
  - fill counter `fill`, 0..MAX_LEN, saturating at MAX_LEN.
- Effective delay: `L = min(dly, MAX_LEN)`, evaluated combinationally every cycle.
- Enabled edge without reset: `mem[wptr] <= in`; `wptr <= wptr + 1` (wrap MAX_LEN-1 → 0); `fill <= min(fill+1, MAX_LEN)`.
- `en` low: no state change; `out` and `out_vld` hold, since they depend only on state and `dly`.
- Read, combinational from registered state:
  - `L == 0`: `out = in`, `out_vld = 1` (pure passthrough, same as a zero-length chain).
  - `L ≥ 1`: `rptr = (wptr - L) mod MAX_LEN`; `out_vld = (fill ≥ L)`; `out = out_vld ? mem[rptr] : 0`.
- `dly` changes take effect in the same cycle.
  - Decrease: `out` jumps to a newer stored sample.
  - Increase: `out` reads older history if `fill` covers it; otherwise `out_vld` drops and `out = 0`.
  - No samples are lost or duplicated in the buffer. Only the read tap moves.
- `L == MAX_LEN`: `rptr == wptr`. This reads the oldest entry, which is overwritten on the next enabled edge. It is legal and required to work.
- Arithmetic: pointer subtraction is modulo MAX_LEN with no borrow logic beyond the truncated width. `fill` compare is unsigned on AW bits.

## Timing
- Reset (`rst` high at an edge): `wptr = 0`, `fill = 0`. `mem` contents are don't-care.
- After reset: `out = 0`, `out_vld = 0` for `dly ≥ 1`. For `dly = 0`: `out = in`, `out_vld = 1`.
- `rst` and `en` both high: reset wins, and no write occurs.
- Reset mid-stream: all history is discarded. Validity restarts, so the next `L` enabled edges are needed before `out_vld` rises.
- Latency with fixed `L ≥ 1`: the sample captured on enabled edge n appears on `out` after enabled edge n+L-1. It stays until the next enabled edge.
- First valid output: `out_vld` rises after the L-th enabled edge since reset and never falls while `dly` is constant.
- No combinational path from `in` to `out` except when `L == 0`.
- One read port and one write port into `mem`. Maps to distributed RAM or registers.

## Test plan
- Reset values: `rst` pulse, `dly = 4`, `en = 0` → `out = 0`, `out_vld = 0`. Set `dly = 0`, `in = 8'hA5` → `out = 8'hA5`, `out_vld = 1` in the same cycle.
- Fixed delay: `dly = 4`, `en = 1` continuously, `in = k` at edge k (k = 1..20) → `out_vld` low through edge 3. After edge 4, `out = 1`, `out_vld = 1`. After edge n, `out = n-3` through n = 20, covering pointer wrap at 16.
- Enable gaps: `dly = 3`, `en` pattern 1,0,0,1,1,0,1 with `in = 10,11,12,13,14,15,16` → output advances only on enabled edges. After the 4th enabled write (`in = 16`), `out = 13`; `out` holds during `en = 0`.
- Delay change: run `dly = 4` for 10 enabled writes of `in = k`, so `out = 7`. Switch to `dly = 2` → `out = 9` immediately. Switch to `dly = 12` → `out_vld = 0`, `out = 0` (fill = 10 < 12). Two more writes → `out_vld = 1`, `out = 1`.
- Clamp and full depth: `MAX_LEN = 16`, `dly = 20`, 40 enabled writes of `in = k` → behaves as `L = 16`. First valid after edge 16 with `out = 1`; after edge 40, `out = 25`.
- Reset mid-stream: `dly = 2`, 8 writes, then `rst` high together with `en = 1` and `in = 99` → no write. `out = 0`, `out_vld = 0`. Next writes `in = 50, 51` → `out = 50`, `out_vld = 1` after the second.

Source files
------------

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: circular buffer with a write pointer and a
// read tap placed L enabled samples behind it, L = min(dly, MAX_LEN).
module var_delay_line #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] dly,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic          out_vld
);

  localparam int unsigned   PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0] MAX_L = AW'(MAX_LEN);

  logic [DW-1:0] mem [MAX_LEN];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [AW-1:0] fill;
  logic [AW-1:0] eff_len;

  // Pointer and saturating fill count; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      fill <= '0;
    end else if (en) begin
      wptr <= wptr + PW'(1);
      if (fill != MAX_L) begin
        fill <= fill + AW'(1);
      end
    end
  end

  // Sample storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[wptr] <= in;
    end
  end

  // L == MAX_LEN truncates to zero, so the tap lands on wptr (oldest entry).
  always_comb begin
    eff_len = (dly > MAX_L) ? MAX_L : dly;
    rptr    = wptr - PW'(eff_len);
  end

  always_comb begin
    out     = '0;
    out_vld = 1'b0;
    if (eff_len == '0) begin
      out     = in;
      out_vld = 1'b1;
    end else if (fill >= eff_len) begin
      out     = mem[rptr];
      out_vld = 1'b1;
    end
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: sample-history reference model feeding a
// scoreboard queue that a negedge monitor drains and compares.
module tb_var_delay_line;

  localparam int unsigned DW      = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned AW      = $clog2(MAX_LEN + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [AW-1:0] dly;
  logic [DW-1:0] in;
  logic [DW-1:0] out;
  logic          out_vld;

  var_delay_line #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .dly(dly), .in(in),
    .out(out), .out_vld(out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [63:0] tag;
    logic [7:0]  o;
    logic        v;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] hist [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       cur_rst;
  logic       cur_en;
  logic [7:0] cur_in;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (out !== e.o || out_vld !== e.v) begin
        errors++;
        $display("FAIL %0s cyc=%0d: got out=%0d vld=%b, want out=%0d vld=%b",
                 e.tag, cyc, out, out_vld, e.o, e.v);
      end
    end
  end

  // Set inputs for this cycle and queue what the history model predicts.
  task automatic apply(input logic r, input logic e, input int d, input logic [7:0] x);
    int   l;
    exp_t ex;
    rst = r; en = e; dly = AW'(d); in = x;
    cur_rst = r; cur_en = e; cur_in = x;
    l = (d > int'(MAX_LEN)) ? int'(MAX_LEN) : d;
    ex.cyc = cyc;
    ex.tag = "model";
    if (l == 0) begin
      ex.o = x; ex.v = 1'b1;
    end else if (hist.size() >= l) begin
      ex.o = hist[hist.size() - l]; ex.v = 1'b1;
    end else begin
      ex.o = 8'd0; ex.v = 1'b0;
    end
    sbq.push_back(ex);
  endtask

  // Literal expectation from the written test plan for the current cycle.
  task automatic lit(input logic [7:0] o, input logic v, input logic [63:0] tag);
    exp_t ex;
    ex.cyc = cyc; ex.tag = tag; ex.o = o; ex.v = v;
    sbq.push_back(ex);
  endtask

  // Advance one edge and update the model history.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cur_rst) hist.delete();
    else if (cur_en) begin
      hist.push_back(cur_in);
      if (hist.size() > 2 * MAX_LEN) void'(hist.pop_front());
    end
  endtask

  task automatic do_reset(input int d);
    apply(1'b1, 1'b0, d, 8'd0);
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] gap_in [7];
    logic       gap_en [7];
    int         d;
    rst = 1'b1; en = 1'b0; dly = '0; in = '0;
    cur_rst = 1'b1; cur_en = 1'b0; cur_in = '0;
    @(posedge clk); #1;

    // Reset values and zero-delay passthrough
    do_reset(4);
    apply(1'b0, 1'b0, 4, 8'd0);    lit(8'd0, 1'b0, "rst_val");  tick();
    apply(1'b0, 1'b0, 0, 8'hA5);   lit(8'hA5, 1'b1, "pass0");   tick();

    // Fixed delay 4 across pointer wrap
    do_reset(4);
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, 1'b1, 4, 8'(k));
      lit((k - 1 >= 4) ? 8'(k - 4) : 8'd0, (k - 1 >= 4), "fixed4");
      tick();
    end
    apply(1'b0, 1'b0, 4, 8'd0);    lit(8'd17, 1'b1, "fixed_end"); tick();

    // Enable gaps
    gap_en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_in = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    do_reset(3);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, gap_en[i], 3, gap_in[i]);
      tick();
    end
    apply(1'b0, 1'b0, 3, 8'd0);    lit(8'd13, 1'b1, "gap");      tick();
    apply(1'b0, 1'b0, 3, 8'd0);    lit(8'd13, 1'b1, "gap_hold"); tick();

    // Delay changes move only the read tap
    do_reset(4);
    for (int k = 1; k <= 10; k++) begin
      apply(1'b0, 1'b1, 4, 8'(k));
      tick();
    end
    apply(1'b0, 1'b0, 4, 8'd0);    lit(8'd7, 1'b1, "dly4");   tick();
    apply(1'b0, 1'b0, 2, 8'd0);    lit(8'd9, 1'b1, "dly2");   tick();
    apply(1'b0, 1'b0, 12, 8'd0);   lit(8'd0, 1'b0, "dly12");  tick();
    apply(1'b0, 1'b1, 12, 8'd11);  tick();
    apply(1'b0, 1'b1, 12, 8'd12);  tick();
    apply(1'b0, 1'b0, 12, 8'd0);   lit(8'd1, 1'b1, "dly12v"); tick();

    // Clamp 20 -> 16 and full-depth read
    do_reset(20);
    for (int k = 1; k <= 40; k++) begin
      apply(1'b0, 1'b1, 20, 8'(k));
      lit((k - 1 >= 16) ? 8'(k - 16) : 8'd0, (k - 1 >= 16), "clamp");
      tick();
    end
    apply(1'b0, 1'b0, 20, 8'd0);   lit(8'd25, 1'b1, "clamp_end"); tick();

    // Reset mid-stream beats enable
    do_reset(2);
    for (int k = 1; k <= 8; k++) begin
      apply(1'b0, 1'b1, 2, 8'($urandom_range(0, 255)));
      tick();
    end
    apply(1'b1, 1'b1, 2, 8'd99);   tick();
    apply(1'b0, 1'b0, 2, 8'd0);    lit(8'd0, 1'b0, "midrst");  tick();
    apply(1'b0, 1'b1, 2, 8'd50);   tick();
    apply(1'b0, 1'b1, 2, 8'd51);   lit(8'd0, 1'b0, "midrst1"); tick();
    apply(1'b0, 1'b0, 2, 8'd0);    lit(8'd50, 1'b1, "midrst2"); tick();

    // Randomized traffic against the history model
    d = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) d = int'($urandom_range(0, 31));
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), d,
            8'($urandom_range(0, 255)));
      tick();
    end

    apply(1'b0, 1'b0, d, 8'd0);
    tick();
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
